// File: rtl/out_flat_signature_collector_pkg.sv
// Shared definitions for the out_flat signature collector: state encoding,
// signature width, default MISR polynomial and the 32-bit fold of a sample.
package sigcol_pkg;

   localparam int SIG_W = 32;
   localparam int FOLD_DATA_W = 159;
   localparam logic [SIG_W-1:0] DEFAULT_POLY = 32'h04C1_1DB7;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      COLLECT = 2'd1,
      DONE    = 2'd2
   } state_t;

   // Zero-pad the sample up to a whole number of 32-bit chunks and XOR the
   // chunks together, so the top partial chunk lands on the low fold bits.
   function automatic logic [SIG_W-1:0] fold32(input logic [FOLD_DATA_W-1:0] data);
      localparam int PAD_W = ((FOLD_DATA_W + SIG_W - 1) / SIG_W) * SIG_W;
      logic [PAD_W-1:0] padded;
      logic [SIG_W-1:0] acc;
      padded = '0;
      padded[FOLD_DATA_W-1:0] = data;
      acc = '0;
      for (int i = 0; i < PAD_W / SIG_W; i++) begin
         acc = acc ^ padded[i*SIG_W +: SIG_W];
      end
      return acc;
   endfunction

endpackage

// File: rtl/out_flat_signature_collector_if.sv
// Sample/control bus between the run-control side (master) and the
// signature collector (slave). The mask signal exists only when OUT_MASK_EN
// is defined.
interface out_flat_signature_collector_if #(
   parameter int DATA_W = 159,
   parameter int CNT_W  = 16
);
   logic              start;
   logic [CNT_W-1:0]  num_samples;
   logic              sample_valid;
   logic [DATA_W-1:0] sample_data;
`ifdef OUT_MASK_EN
   logic [DATA_W-1:0] mask;
`endif
   logic              busy;
   logic              done;
   logic [31:0]       signature;
   logic [CNT_W-1:0]  sample_count;

`ifdef OUT_MASK_EN
   modport master (
      output start, num_samples, sample_valid, sample_data, mask,
      input  busy, done, signature, sample_count
   );
   modport slave (
      input  start, num_samples, sample_valid, sample_data, mask,
      output busy, done, signature, sample_count
   );
`else
   modport master (
      output start, num_samples, sample_valid, sample_data,
      input  busy, done, signature, sample_count
   );
   modport slave (
      input  start, num_samples, sample_valid, sample_data,
      output busy, done, signature, sample_count
   );
`endif

endinterface

// File: rtl/out_flat_signature_collector_misr32.sv
// 32-bit Galois MISR. A load replaces the signature outright; otherwise an
// enabled cycle shifts left, applies the polynomial when the top bit falls
// out, and XORs in the folded sample.
module misr32
   import sigcol_pkg::*;
#(
   parameter logic [SIG_W-1:0] POLY = DEFAULT_POLY
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic [SIG_W-1:0] load_val,
   input  logic             en,
   input  logic [SIG_W-1:0] fold_in,
   output logic [SIG_W-1:0] sig
);

   logic [SIG_W-1:0] sig_q;

   // Signature register: reset clears, load seeds, enable compacts one sample.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sig_q <= '0;
      end else if (load) begin
         sig_q <= load_val;
      end else if (en) begin
         sig_q <= {sig_q[SIG_W-2:0], 1'b0} ^ (sig_q[SIG_W-1] ? POLY : '0) ^ fold_in;
      end
   end

   assign sig = sig_q;

endmodule

// File: rtl/out_flat_signature_collector.sv
// Compacts the DUT out_flat bus into a 32-bit MISR signature over a
// programmed number of valid samples. Holds the run FSM, sample counter and
// target; the signature itself lives in misr32.
// Optional feature: define OUT_MASK_EN to add a mask input whose set bits are
// cleared from each sample before compaction.
module out_flat_signature_collector
   import sigcol_pkg::*;
#(
   parameter int               DATA_W = FOLD_DATA_W,
   parameter int               CNT_W  = 16,
   parameter logic [SIG_W-1:0] SEED   = 32'h0000_0001,
   parameter logic [SIG_W-1:0] POLY   = DEFAULT_POLY
) (
   input logic clk,
   input logic rst_n,
   out_flat_signature_collector_if.slave bus
);

   state_t            state_q;
   state_t            state_d;
   logic [CNT_W-1:0]  count_q;
   logic [CNT_W-1:0]  target_q;
   logic [CNT_W-1:0]  count_inc;
   logic              start_ok;
   logic              sample_ok;
   logic [DATA_W-1:0] data_eff;
   logic [SIG_W-1:0]  fold_val;

`ifdef OUT_MASK_EN
   assign data_eff = bus.sample_data & ~bus.mask;
`else
   assign data_eff = bus.sample_data;
`endif

   assign fold_val  = fold32(data_eff);
   assign count_inc = count_q + CNT_W'(1);
   assign start_ok  = bus.start && (state_q != COLLECT);
   assign sample_ok = bus.sample_valid && (state_q == COLLECT);

   // State register; reset always returns to IDLE and aborts any run.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic: start is only honoured outside COLLECT, and a run ends
   // on the sample that brings the count up to the target.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE, DONE: begin
            if (bus.start) begin
               state_d = (bus.num_samples == '0) ? DONE : COLLECT;
            end
         end
         COLLECT: begin
            if (bus.sample_valid && (count_inc == target_q)) begin
               state_d = DONE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Sample counter and latched target for the current run.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         count_q  <= '0;
         target_q <= '0;
      end else if (start_ok) begin
         count_q  <= '0;
         target_q <= bus.num_samples;
      end else if (sample_ok) begin
         count_q  <= count_inc;
      end
   end

   misr32 #(
      .POLY (POLY)
   ) u_misr (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (start_ok),
      .load_val (SEED),
      .en       (sample_ok),
      .fold_in  (fold_val),
      .sig      (bus.signature)
   );

   assign bus.busy         = (state_q == COLLECT);
   assign bus.done         = (state_q == DONE);
   assign bus.sample_count = count_q;

endmodule

// File: tb/tb_out_flat_signature_collector.sv
// Self-checking bench for out_flat_signature_collector. Three collectors with
// different seeds share one stimulus stream; a behavioural model predicts
// every output from the run rules. Define OUT_MASK_EN to cover the mask port.
module tb_out_flat_signature_collector;

   localparam int DATA_W = 159;
   localparam int CNT_W  = 16;
   localparam logic [31:0] POLY = 32'h04C1_1DB7;
   localparam logic [31:0] SEED_A = 32'h0000_0001;
   localparam logic [31:0] SEED_B = 32'h0000_0000;
   localparam logic [31:0] SEED_C = 32'h8000_0000;

   logic              clk;
   logic              rst_n;
   logic              start;
   logic [CNT_W-1:0]  num_samples;
   logic              sample_valid;
   logic [DATA_W-1:0] sample_data;
   logic [DATA_W-1:0] mask;

   int vectors;
   int miscompares;

   // Model state
   logic        m_running;
   logic        m_done;
   logic [31:0] m_sig [3];
   logic [31:0] m_seed [3];
   int          m_cnt;
   int          m_tgt;

   out_flat_signature_collector_if #(.DATA_W(DATA_W), .CNT_W(CNT_W)) if_a ();
   out_flat_signature_collector_if #(.DATA_W(DATA_W), .CNT_W(CNT_W)) if_b ();
   out_flat_signature_collector_if #(.DATA_W(DATA_W), .CNT_W(CNT_W)) if_c ();

   assign if_a.start = start;        assign if_b.start = start;        assign if_c.start = start;
   assign if_a.num_samples = num_samples;
   assign if_b.num_samples = num_samples;
   assign if_c.num_samples = num_samples;
   assign if_a.sample_valid = sample_valid;
   assign if_b.sample_valid = sample_valid;
   assign if_c.sample_valid = sample_valid;
   assign if_a.sample_data = sample_data;
   assign if_b.sample_data = sample_data;
   assign if_c.sample_data = sample_data;
`ifdef OUT_MASK_EN
   assign if_a.mask = mask;          assign if_b.mask = mask;          assign if_c.mask = mask;
`endif

   out_flat_signature_collector #(.DATA_W(DATA_W), .CNT_W(CNT_W), .SEED(SEED_A), .POLY(POLY))
      dut_a (.clk(clk), .rst_n(rst_n), .bus(if_a));
   out_flat_signature_collector #(.DATA_W(DATA_W), .CNT_W(CNT_W), .SEED(SEED_B), .POLY(POLY))
      dut_b (.clk(clk), .rst_n(rst_n), .bus(if_b));
   out_flat_signature_collector #(.DATA_W(DATA_W), .CNT_W(CNT_W), .SEED(SEED_C), .POLY(POLY))
      dut_c (.clk(clk), .rst_n(rst_n), .bus(if_c));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Each output bit j of the fold is the parity of every data bit at i % 32 == j.
   function automatic logic [31:0] ref_fold(input logic [DATA_W-1:0] d);
      logic [31:0] f;
      f = '0;
      for (int i = 0; i < DATA_W; i++) begin
         if (d[i]) f[i % 32] = ~f[i % 32];
      end
      return f;
   endfunction

   // One MISR step: multiply by x modulo the polynomial, then add the fold.
   function automatic logic [31:0] ref_misr(input logic [31:0] s, input logic [31:0] f);
      logic [31:0] n;
      n = s << 1;
      if (s[31]) n = n ^ POLY;
      return n ^ f;
   endfunction

   function automatic logic [DATA_W-1:0] rand_data();
      logic [159:0] r;
      r = {$urandom, $urandom, $urandom, $urandom, $urandom};
      return r[DATA_W-1:0];
   endfunction

   // Advance the model by one clock using the inputs currently applied.
   task automatic model_step();
      logic [DATA_W-1:0] d;
      if (!rst_n) begin
         m_running = 1'b0; m_done = 1'b0; m_cnt = 0; m_tgt = 0;
         for (int k = 0; k < 3; k++) m_sig[k] = '0;
      end else if (!m_running && start) begin
         for (int k = 0; k < 3; k++) m_sig[k] = m_seed[k];
         m_cnt = 0;
         m_tgt = int'(num_samples);
         m_running = (num_samples != '0);
         m_done    = (num_samples == '0);
      end else if (m_running && sample_valid) begin
         d = sample_data;
`ifdef OUT_MASK_EN
         d = d & ~mask;
`endif
         for (int k = 0; k < 3; k++) m_sig[k] = ref_misr(m_sig[k], ref_fold(d));
         m_cnt = m_cnt + 1;
         if (m_cnt == m_tgt) begin
            m_running = 1'b0;
            m_done    = 1'b1;
         end
      end
   endtask

   // Apply one cycle of inputs, clock it, update the model, settle outputs.
   task automatic drive_cycle(input logic r, input logic s, input logic [CNT_W-1:0] n,
                              input logic v, input logic [DATA_W-1:0] d);
      rst_n = r; start = s; num_samples = n; sample_valid = v; sample_data = d;
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic test_reset();
      drive_cycle(1'b0, 1'b0, '0, 1'b0, '0);
      drive_cycle(1'b0, 1'b0, '0, 1'b0, '0);
      vectors += 4;
      if (if_a.busy !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_busy got %b want 0", if_a.busy); end
      if (if_a.done !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_done got %b want 0", if_a.done); end
      if (if_a.signature !== 32'h0) begin miscompares++; $display("[TB] FAIL reset_sig got %h want 0", if_a.signature); end
      if (if_a.sample_count !== '0) begin miscompares++; $display("[TB] FAIL reset_count got %0d want 0", if_a.sample_count); end
   endtask

   task automatic test_single_zero();
      drive_cycle(1'b1, 1'b1, 16'd1, 1'b0, '0);
      vectors += 2;
      if (if_a.busy !== 1'b1) begin miscompares++; $display("[TB] FAIL start_busy got %b want 1", if_a.busy); end
      if (if_a.signature !== SEED_A) begin miscompares++; $display("[TB] FAIL start_seed got %h want %h", if_a.signature, SEED_A); end
      drive_cycle(1'b1, 1'b0, '0, 1'b1, '0);
      vectors += 6;
      if (if_a.signature !== 32'h2) begin miscompares++; $display("[TB] FAIL zero_sig_a got %h want 00000002", if_a.signature); end
      if (if_c.signature !== 32'h04C1_1DB7) begin miscompares++; $display("[TB] FAIL zero_sig_c got %h want 04c11db7", if_c.signature); end
      if (if_b.signature !== 32'h0) begin miscompares++; $display("[TB] FAIL zero_sig_b got %h want 0", if_b.signature); end
      if (if_a.sample_count !== 16'd1) begin miscompares++; $display("[TB] FAIL zero_count got %0d want 1", if_a.sample_count); end
      if (if_a.done !== 1'b1) begin miscompares++; $display("[TB] FAIL zero_done got %b want 1", if_a.done); end
      if (if_a.busy !== 1'b0) begin miscompares++; $display("[TB] FAIL zero_busy got %b want 0", if_a.busy); end
   endtask

   task automatic test_fold_bits();
      logic [DATA_W-1:0] d;
      int bits [3];
      logic [31:0] want_b [3];
      bits[0] = 128; bits[1] = 0; bits[2] = 158;
      want_b[0] = 32'h1; want_b[1] = 32'h1; want_b[2] = 32'h4000_0000;
      for (int t = 0; t < 3; t++) begin
         d = '0;
         d[bits[t]] = 1'b1;
         drive_cycle(1'b1, 1'b1, 16'd1, 1'b0, '0);
         drive_cycle(1'b1, 1'b0, '0, 1'b1, d);
         vectors += 2;
         if (if_b.signature !== want_b[t]) begin
            miscompares++;
            $display("[TB] FAIL fold_bit%0d_sig_b got %h want %h", bits[t], if_b.signature, want_b[t]);
         end
         if (if_a.signature !== (32'h2 ^ want_b[t])) begin
            miscompares++;
            $display("[TB] FAIL fold_bit%0d_sig_a got %h want %h", bits[t], if_a.signature, 32'h2 ^ want_b[t]);
         end
      end
   endtask

   task automatic test_stall_and_midrun_start();
      logic v_pat [5];
      int   want_cnt [5];
      logic [DATA_W-1:0] d;
      v_pat[0] = 1; v_pat[1] = 0; v_pat[2] = 1; v_pat[3] = 0; v_pat[4] = 1;
      want_cnt[0] = 1; want_cnt[1] = 1; want_cnt[2] = 2; want_cnt[3] = 2; want_cnt[4] = 3;
      drive_cycle(1'b1, 1'b1, 16'd3, 1'b0, '0);
      for (int i = 0; i < 5; i++) begin
         d = rand_data();
         drive_cycle(1'b1, (i == 1), 16'd7, v_pat[i], d);
         vectors += 4;
         if (if_a.sample_count !== CNT_W'(want_cnt[i])) begin
            miscompares++; $display("[TB] FAIL stall_count[%0d] got %0d want %0d", i, if_a.sample_count, want_cnt[i]);
         end
         if (if_a.done !== (i == 4)) begin
            miscompares++; $display("[TB] FAIL stall_done[%0d] got %b want %b", i, if_a.done, (i == 4));
         end
         if (if_a.busy !== (i != 4)) begin
            miscompares++; $display("[TB] FAIL stall_busy[%0d] got %b want %b", i, if_a.busy, (i != 4));
         end
         if (if_c.signature !== m_sig[2]) begin
            miscompares++; $display("[TB] FAIL stall_sig_c[%0d] got %h want %h", i, if_c.signature, m_sig[2]);
         end
      end
      drive_cycle(1'b1, 1'b1, 16'd2, 1'b1, rand_data());
      vectors += 3;
      if (if_a.signature !== SEED_A) begin miscompares++; $display("[TB] FAIL startwins_sig got %h want %h", if_a.signature, SEED_A); end
      if (if_a.sample_count !== '0) begin miscompares++; $display("[TB] FAIL startwins_count got %0d want 0", if_a.sample_count); end
      if (if_a.busy !== 1'b1) begin miscompares++; $display("[TB] FAIL startwins_busy got %b want 1", if_a.busy); end
   endtask

   task automatic test_reset_midrun();
      drive_cycle(1'b1, 1'b1, 16'd5, 1'b0, '0);
      drive_cycle(1'b1, 1'b0, '0, 1'b1, rand_data());
      drive_cycle(1'b1, 1'b0, '0, 1'b1, rand_data());
      vectors += 1;
      if (if_a.sample_count !== 16'd2) begin miscompares++; $display("[TB] FAIL midrun_count got %0d want 2", if_a.sample_count); end
      drive_cycle(1'b0, 1'b0, '0, 1'b1, rand_data());
      vectors += 4;
      if (if_a.busy !== 1'b0) begin miscompares++; $display("[TB] FAIL abort_busy got %b want 0", if_a.busy); end
      if (if_a.done !== 1'b0) begin miscompares++; $display("[TB] FAIL abort_done got %b want 0", if_a.done); end
      if (if_a.signature !== 32'h0) begin miscompares++; $display("[TB] FAIL abort_sig got %h want 0", if_a.signature); end
      if (if_a.sample_count !== '0) begin miscompares++; $display("[TB] FAIL abort_count got %0d want 0", if_a.sample_count); end
      drive_cycle(1'b1, 1'b1, 16'd0, 1'b0, '0);
      vectors += 3;
      if (if_a.done !== 1'b1) begin miscompares++; $display("[TB] FAIL zero_run_done got %b want 1", if_a.done); end
      if (if_a.signature !== SEED_A) begin miscompares++; $display("[TB] FAIL zero_run_sig_a got %h want %h", if_a.signature, SEED_A); end
      if (if_c.signature !== SEED_C) begin miscompares++; $display("[TB] FAIL zero_run_sig_c got %h want %h", if_c.signature, SEED_C); end
      drive_cycle(1'b1, 1'b0, '0, 1'b1, rand_data());
      vectors += 2;
      if (if_a.signature !== SEED_A) begin miscompares++; $display("[TB] FAIL done_ignore_sig got %h want %h", if_a.signature, SEED_A); end
      if (if_a.sample_count !== '0) begin miscompares++; $display("[TB] FAIL done_ignore_count got %0d want 0", if_a.sample_count); end
   endtask

   task automatic test_random_runs();
      int cycles;
      for (int run = 0; run < 20; run++) begin
         drive_cycle(1'b1, 1'b1, CNT_W'($urandom_range(1, 6)), 1'b0, '0);
         cycles = 0;
         while (!m_done && cycles < 100) begin
            drive_cycle(1'b1, ($urandom_range(0, 4) == 0), CNT_W'($urandom_range(0, 9)),
                        $urandom_range(0, 1) == 1, rand_data());
            cycles++;
            vectors += 6;
            if (if_a.busy !== m_running) begin miscompares++; $display("[TB] FAIL rand_busy run%0d got %b want %b", run, if_a.busy, m_running); end
            if (if_a.done !== m_done) begin miscompares++; $display("[TB] FAIL rand_done run%0d got %b want %b", run, if_a.done, m_done); end
            if (if_a.sample_count !== CNT_W'(m_cnt)) begin miscompares++; $display("[TB] FAIL rand_count run%0d got %0d want %0d", run, if_a.sample_count, m_cnt); end
            if (if_a.signature !== m_sig[0]) begin miscompares++; $display("[TB] FAIL rand_sig_a run%0d got %h want %h", run, if_a.signature, m_sig[0]); end
            if (if_b.signature !== m_sig[1]) begin miscompares++; $display("[TB] FAIL rand_sig_b run%0d got %h want %h", run, if_b.signature, m_sig[1]); end
            if (if_c.signature !== m_sig[2]) begin miscompares++; $display("[TB] FAIL rand_sig_c run%0d got %h want %h", run, if_c.signature, m_sig[2]); end
         end
         vectors++;
         if (!m_done || if_a.done !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL rand_run%0d_finish got done=%b want 1 within 100 cycles", run, if_a.done);
         end
      end
   endtask

`ifdef OUT_MASK_EN
   task automatic test_mask();
      mask = '1;
      drive_cycle(1'b1, 1'b1, 16'd1, 1'b0, '0);
      drive_cycle(1'b1, 1'b0, '0, 1'b1, rand_data());
      vectors += 2;
      if (if_a.signature !== 32'h2) begin miscompares++; $display("[TB] FAIL mask_sig_a got %h want 00000002", if_a.signature); end
      if (if_b.signature !== 32'h0) begin miscompares++; $display("[TB] FAIL mask_sig_b got %h want 0", if_b.signature); end
      mask = '0;
   endtask
`endif

   initial begin
      vectors = 0;
      miscompares = 0;
      m_seed[0] = SEED_A; m_seed[1] = SEED_B; m_seed[2] = SEED_C;
      m_running = 1'b0; m_done = 1'b0; m_cnt = 0; m_tgt = 0;
      for (int k = 0; k < 3; k++) m_sig[k] = '0;
      rst_n = 1'b0; start = 1'b0; num_samples = '0; sample_valid = 1'b0;
      sample_data = '0; mask = '0;

      test_reset();
      test_single_zero();
      test_fold_bits();
      test_stall_and_midrun_start();
      test_reset_midrun();
      test_random_runs();
`ifdef OUT_MASK_EN
      test_mask();
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
